toy_dispatch_sched: RTL and testbench

//  In-order dispatch scheduler that sits in front of the dispatch crossbar. It resolves execution-unit (EU) class conflicts

---
 rtl/toy_dispatch_sched_if.sv | 33 +++
 rtl/toy_dispatch_sched.sv | 117 +++++++++++
 tb/tb_toy_dispatch_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/toy_dispatch_sched_if.sv
// Bundle/dispatch interface between the decode stage, the dispatch scheduler
// and the dispatch crossbar.
//
// Handshake: upstream raises bndl_vld with a payload (bndl_lane_vld, bndl_goto)
// and keeps that payload stable until it sees bndl_rdy high in the same cycle
// as bndl_vld. bndl_rdy high while bndl_vld is high means the bundle is consumed
// at that clock edge. bndl_rdy is also high during flush, which discards the
// bundle. v_eu_vld / eu_issue_vld are per-cycle grants with no handshake back.
interface toy_dispatch_sched_if #(
  parameter int LANE_NUM = 4,
  parameter int EU_NUM   = 4
);
  logic                         bndl_vld;
  logic                         bndl_rdy;
  logic [LANE_NUM-1:0]          bndl_lane_vld;
  logic [LANE_NUM*EU_NUM-1:0]   bndl_goto;
  logic [EU_NUM-1:0]            eu_rdy;
  logic                         flush;
  logic [LANE_NUM-1:0]          v_eu_vld;
  logic [EU_NUM-1:0]            eu_issue_vld;

  // Decode/EU side driving the scheduler
  modport master (
    output bndl_vld, bndl_lane_vld, bndl_goto, eu_rdy, flush,
    input  bndl_rdy, v_eu_vld, eu_issue_vld
  );

  // Scheduler side
  modport slave (
    input  bndl_vld, bndl_lane_vld, bndl_goto, eu_rdy, flush,
    output bndl_rdy, v_eu_vld, eu_issue_vld
  );
endinterface

// File: rtl/toy_dispatch_sched.sv
// In-order dispatch scheduler. Grants decode-bundle lanes to the dispatch
// crossbar in program order, at most one lane per EU class per cycle, honouring
// per-class backpressure, and holds the bundle until every valid lane issued.
module toy_dispatch_sched #(
  parameter int LANE_NUM = 4,
  parameter int EU_NUM   = 4,
  parameter int STALL_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  toy_dispatch_sched_if.slave bus,
  output logic               goto_err,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PART = 1'b1
  } state_t;

  localparam logic [EU_NUM-1:0] EU_ONE = {{(EU_NUM-1){1'b0}}, 1'b1};

  state_t              state;
  logic [LANE_NUM-1:0] done_q;
  logic [LANE_NUM-1:0] pending;
  logic [LANE_NUM-1:0] grant;
  logic [LANE_NUM-1:0] classless;
  logic [LANE_NUM-1:0] multi_hot;
  logic [EU_NUM-1:0]   cls_oh [LANE_NUM];
  logic [EU_NUM-1:0]   used;
  logic                blocked;
  logic                rdy;
  logic                complete;
  logic                goto_bad;

  assign pending = {LANE_NUM{bus.bndl_vld}} & bus.bndl_lane_vld & ~done_q;

  // Per-lane decode: class is the lowest set goto bit; flag empty and multi-hot fields
  always_comb begin
    for (int i = 0; i < LANE_NUM; i++) begin
      cls_oh[i]    = bus.bndl_goto[i*EU_NUM +: EU_NUM]
                   & (~bus.bndl_goto[i*EU_NUM +: EU_NUM] + EU_ONE);
      classless[i] = (bus.bndl_goto[i*EU_NUM +: EU_NUM] == '0);
      multi_hot[i] = |(bus.bndl_goto[i*EU_NUM +: EU_NUM]
                   & (bus.bndl_goto[i*EU_NUM +: EU_NUM] - EU_ONE));
    end
  end

  // Program-order grant scan; the first pending lane that cannot go blocks all younger lanes
  always_comb begin
    grant   = '0;
    used    = '0;
    blocked = 1'b0;
    for (int i = 0; i < LANE_NUM; i++) begin
      if (pending[i] && !blocked) begin
        if (classless[i]) begin
          grant[i] = 1'b1;
        end else if (((cls_oh[i] & bus.eu_rdy) != '0) && ((cls_oh[i] & used) == '0)) begin
          grant[i] = 1'b1;
          used     = used | cls_oh[i];
        end else begin
          blocked = 1'b1;
        end
      end
    end
    // Flush and reset suppress every grant
    if (bus.flush || !rst_n) begin
      grant = '0;
      used  = '0;
    end
  end

  assign rdy      = bus.flush | (bus.bndl_vld & ((pending & ~grant) == '0));
  assign complete = bus.bndl_vld & rdy;
  assign goto_bad = |(pending & multi_hot);

  assign bus.v_eu_vld     = grant;
  assign bus.eu_issue_vld = used;
  assign bus.bndl_rdy     = rst_n & rdy;
  assign busy             = (state == ST_PART);

  // Bundle-progress FSM: tracks dispatched lanes and whether a bundle is part-issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      done_q <= '0;
    end else begin
      if (bus.flush || complete) begin
        done_q <= '0;
      end else begin
        done_q <= done_q | grant;
      end
      case (state)
        ST_IDLE: if (!bus.flush && (grant != '0) && !complete) state <= ST_PART;
        ST_PART: if (bus.flush || complete)                    state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // No-progress counter and sticky malformed-goto flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      goto_err  <= 1'b0;
    end else begin
      if (bus.flush || !bus.bndl_vld || (grant != '0)) begin
        stall_cnt <= '0;
      end else if ((pending != '0) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
      if (goto_bad) goto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_toy_dispatch_sched.sv
// Directed table-driven bench for toy_dispatch_sched plus hand-written
// sequences for asynchronous reset mid-bundle and stall counter saturation.
module tb_toy_dispatch_sched;

  logic       clk;
  logic       rst_n;
  logic       goto_err;
  logic [7:0] stall_cnt;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  toy_dispatch_sched_if #(.LANE_NUM(4), .EU_NUM(4)) bus ();

  toy_dispatch_sched #(.LANE_NUM(4), .EU_NUM(4), .STALL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .goto_err  (goto_err),
    .stall_cnt (stall_cnt),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        vld;
    logic [3:0]  lane;
    logic [15:0] goto_f;
    logic [3:0]  rdy;
    logic        flush;
    logic [3:0]  e_v;
    logic [3:0]  e_iss;
    logic        e_rdy;
    logic        e_busy;
    logic [7:0]  e_stall;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [3:0] lane, input logic [15:0] goto_f,
                     input logic [3:0] rdy, input logic flush,
                     input logic [3:0] e_v, input logic [3:0] e_iss, input logic e_rdy,
                     input logic e_busy, input logic [7:0] e_stall, input logic e_err);
    vec_t t;
    t.vld = vld; t.lane = lane; t.goto_f = goto_f; t.rdy = rdy; t.flush = flush;
    t.e_v = e_v; t.e_iss = e_iss; t.e_rdy = e_rdy; t.e_busy = e_busy;
    t.e_stall = e_stall; t.e_err = e_err;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic vld, input logic [3:0] lane, input logic [15:0] goto_f,
                       input logic [3:0] rdy, input logic flush);
    bus.bndl_vld      = vld;
    bus.bndl_lane_vld = lane;
    bus.bndl_goto     = goto_f;
    bus.eu_rdy        = rdy;
    bus.flush         = flush;
  endtask

  // One cycle: drive on negedge, check combinational outputs, then registered ones after the edge
  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    drive(t.vld, t.lane, t.goto_f, t.rdy, t.flush);
    #1;
    chk("v_eu_vld",     idx, 32'(bus.v_eu_vld),     32'(t.e_v));
    chk("eu_issue_vld", idx, 32'(bus.eu_issue_vld), 32'(t.e_iss));
    chk("bndl_rdy",     idx, 32'(bus.bndl_rdy),     32'(t.e_rdy));
    @(posedge clk);
    #1;
    chk("busy",      idx, 32'(busy),      32'(t.e_busy));
    chk("stall_cnt", idx, 32'(stall_cnt), 32'(t.e_stall));
    chk("goto_err",  idx, 32'(goto_err),  32'(t.e_err));
  endtask

  initial begin
    vec_t t;
    // Table: vld lane goto rdy flush | v iss rdy busy stall err
    // 1: one lane per class, all ready -> single cycle
    add(1, 4'b1111, 16'h8421, 4'hF, 0,  4'b1111, 4'hF, 1, 0, 0, 0);
    // 2: two mext lanes -> split over two cycles
    add(1, 4'b0011, 16'h0011, 4'hF, 0,  4'b0001, 4'b0001, 0, 1, 0, 0);
    add(1, 4'b0011, 16'h0011, 4'hF, 0,  4'b0010, 4'b0001, 1, 0, 0, 0);
    // 3: lane0 float blocked by eu_rdy[1]=0 for 3 cycles, younger mext lane also held
    add(1, 4'b0011, 16'h0012, 4'hD, 0,  4'b0000, 4'b0000, 0, 0, 1, 0);
    add(1, 4'b0011, 16'h0012, 4'hD, 0,  4'b0000, 4'b0000, 0, 0, 2, 0);
    add(1, 4'b0011, 16'h0012, 4'hD, 0,  4'b0000, 4'b0000, 0, 0, 3, 0);
    add(1, 4'b0011, 16'h0012, 4'hF, 0,  4'b0011, 4'b0011, 1, 0, 0, 0);
    // 4: flush in the second cycle of a split bundle, then a fresh bundle from lane 0
    add(1, 4'b0011, 16'h0011, 4'hF, 0,  4'b0001, 4'b0001, 0, 1, 0, 0);
    add(1, 4'b0011, 16'h0011, 4'hF, 1,  4'b0000, 4'b0000, 1, 0, 0, 0);
    add(1, 4'b0011, 16'h0011, 4'hF, 0,  4'b0001, 4'b0001, 0, 1, 0, 0);
    add(1, 4'b0011, 16'h0011, 4'hF, 0,  4'b0010, 4'b0001, 1, 0, 0, 0);
    // idle cycle
    add(0, 4'b0000, 16'h0000, 4'hF, 0,  4'b0000, 4'b0000, 0, 0, 0, 0);
    // empty bundle consumed at once
    add(1, 4'b0000, 16'h1111, 4'hF, 0,  4'b0000, 4'b0000, 1, 0, 0, 0);
    // classless lanes need no eu_rdy and raise no eu_issue_vld
    add(1, 4'b0011, 16'h0000, 4'h0, 0,  4'b0011, 4'b0000, 1, 0, 0, 0);
    // strict order: lane0 mext not ready blocks ready lane1 float
    add(1, 4'b0011, 16'h0021, 4'hE, 0,  4'b0000, 4'b0000, 0, 0, 1, 0);
    add(0, 4'b0000, 16'h0000, 4'hF, 0,  4'b0000, 4'b0000, 0, 0, 0, 0);
    // non-pending lanes are transparent: lanes 1 and 3 both mext
    add(1, 4'b1010, 16'h1010, 4'hF, 0,  4'b0010, 4'b0001, 0, 1, 0, 0);
    add(1, 4'b1010, 16'h1010, 4'hF, 0,  4'b1000, 4'b0001, 1, 0, 0, 0);
    // flush on a fresh bundle: nothing granted, bundle consumed
    add(1, 4'b1111, 16'h8421, 4'hF, 1,  4'b0000, 4'b0000, 1, 0, 0, 0);
    // multi-hot goto on an invalid lane does not set goto_err
    add(1, 4'b0001, 16'h0031, 4'hF, 0,  4'b0001, 4'b0001, 1, 0, 0, 0);
    // 5: lane2 multi-hot treated as mext, lane1 skipped, goto_err sticky
    add(1, 4'b1101, 16'h8314, 4'hF, 0,  4'b1101, 4'b1101, 1, 0, 0, 1);
    add(0, 4'b0000, 16'h0000, 4'hF, 0,  4'b0000, 4'b0000, 0, 0, 0, 1);

    // Reset: inputs active while held in reset; combinational outputs must stay 0
    rst_n = 1'b0;
    drive(1, 4'b1111, 16'h8421, 4'hF, 0);
    #12;
    chk("rst_v_eu_vld",     -1, 32'(bus.v_eu_vld),     32'h0);
    chk("rst_eu_issue_vld", -1, 32'(bus.eu_issue_vld), 32'h0);
    chk("rst_bndl_rdy",     -1, 32'(bus.bndl_rdy),     32'h0);
    chk("rst_busy",         -1, 32'(busy),             32'h0);
    chk("rst_stall_cnt",    -1, 32'(stall_cnt),        32'h0);
    chk("rst_goto_err",     -1, 32'(goto_err),         32'h0);
    drive(0, 4'b0000, 16'h0000, 4'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // 6: asynchronous reset while part-way through a split bundle
    add(1, 4'b0011, 16'h0011, 4'hF, 0,  4'b0001, 4'b0001, 0, 1, 0, 1);
    apply(vecs[vecs.size()-1], 100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_v_eu_vld",     101, 32'(bus.v_eu_vld),     32'h0);
    chk("arst_eu_issue_vld", 101, 32'(bus.eu_issue_vld), 32'h0);
    chk("arst_bndl_rdy",     101, 32'(bus.bndl_rdy),     32'h0);
    chk("arst_busy",         101, 32'(busy),             32'h0);
    chk("arst_goto_err",     101, 32'(goto_err),         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_v_eu_vld", 102, 32'(bus.v_eu_vld),  32'b0001);
    chk("post_rst_busy",     102, 32'(busy),          32'h0);
    chk("post_rst_stall",    102, 32'(stall_cnt),     32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_busy_set", 103, 32'(busy), 32'h1);
    t = vecs[vecs.size()-1];
    t.e_v = 4'b0010; t.e_rdy = 1; t.e_busy = 0; t.e_err = 0;
    apply(t, 104);

    // Stall counter saturates at 255 and clears on flush
    @(negedge clk);
    drive(1, 4'b0001, 16'h0001, 4'h0, 0);
    for (int i = 0; i < 255; i++) begin
      @(posedge clk);
    end
    #1;
    chk("stall_reach_max", 105, 32'(stall_cnt), 32'd255);
    add(1, 4'b0001, 16'h0001, 4'h0, 0,  4'b0000, 4'b0000, 0, 0, 8'd255, 0);
    apply(vecs[vecs.size()-1], 106);
    add(1, 4'b0001, 16'h0001, 4'h0, 1,  4'b0000, 4'b0000, 1, 0, 8'd0, 0);
    apply(vecs[vecs.size()-1], 107);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
